// File: rtl/instr_mem_reader.sv
// Instruction memory read-back engine: streams a program image out over valid/ready with a running sum.
// Define READBACK_CHECKSUM_EN to build the checksum accumulator; otherwise checksum is tied to zero.
module instr_mem_reader #(
    parameter logic [9:0] INITIAL_INSTR_ADDR = 10'h000,
    parameter logic [9:0] NUM_INSTRUCTIONS   = 10'h022
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [9:0]  instr_mem_addr,
    output logic        instr_mem_rd_en,
    input  logic [31:0] instr_mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [9:0]  out_addr,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [9:0] LAST_IDX = NUM_INSTRUCTIONS - 10'd1;

    state_t      state_q, state_d;
    logic        start_prev_q;
    logic [9:0]  addr_q, addr_d;
    logic [9:0]  count_q, count_d;
    logic [9:0]  mem_addr_q, mem_addr_d;
    logic        rd_en_q, rd_en_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [9:0]  out_addr_q, out_addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        start_edge;
`ifdef READBACK_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;
`endif

    assign start_edge = start && !start_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            addr_q       <= '0;
            count_q      <= '0;
            mem_addr_q   <= '0;
            rd_en_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_addr_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef READBACK_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            start_prev_q <= start;
            addr_q       <= addr_d;
            count_q      <= count_d;
            mem_addr_q   <= mem_addr_d;
            rd_en_q      <= rd_en_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_addr_q   <= out_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef READBACK_CHECKSUM_EN
            checksum_q   <= checksum_d;
`endif
        end
    end

    // Outputs are registered, so each transition sets the values seen in the next state.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        mem_addr_d  = mem_addr_q;
        rd_en_d     = rd_en_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        busy_d      = busy_q;
        done_d      = done_q;
`ifdef READBACK_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_edge) begin
                    addr_d  = INITIAL_INSTR_ADDR;
                    count_d = '0;
`ifdef READBACK_CHECKSUM_EN
                    checksum_d = '0;
`endif
                    if (NUM_INSTRUCTIONS == 10'd0) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_READ;
                        busy_d     = 1'b1;
                        done_d     = 1'b0;
                        rd_en_d    = 1'b1;
                        mem_addr_d = INITIAL_INSTR_ADDR;
                    end
                end
            end
            S_READ: begin
                rd_en_d = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                out_data_d  = instr_mem_rdata;
                out_addr_d  = addr_q;
                out_valid_d = 1'b1;
                state_d     = S_PRESENT;
            end
            S_PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    count_d     = count_q + 10'd1;
                    addr_d      = addr_q + 10'd1;
`ifdef READBACK_CHECKSUM_EN
                    checksum_d  = checksum_q + out_data_q;
`endif
                    if (count_q == LAST_IDX) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_READ;
                        rd_en_d    = 1'b1;
                        mem_addr_d = addr_q + 10'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign instr_mem_addr  = mem_addr_q;
    assign instr_mem_rd_en = rd_en_q;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_addr        = out_addr_q;
    assign busy            = busy_q;
    assign done            = done_q;
`ifdef READBACK_CHECKSUM_EN
    assign checksum        = checksum_q;
`else
    assign checksum        = 32'h0;
`endif

endmodule
